pwm_rgb_bank: RTL



---
 rtl/pwm_rgb_bank.sv | 59 +++++
 1 files changed

// File: rtl/pwm_rgb_bank.sv
// pwm_rgb_bank: prescaled, double-buffered CHANNELS x COLORS PWM bank; define PWM_PHASE_STAGGER_EN to phase-shift channels
module pwm_rgb_bank #(
  parameter int CHANNELS = 8,
  parameter int COLORS = 3,
  parameter int RES = 8,
  parameter int PRESCALE = 25,
  parameter int OUT_ACTIVE_LOW = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic [CHANNELS*COLORS*RES-1:0] duty_in,
  input  logic load,
  output logic load_pending,
  output logic period_start,
  output logic [CHANNELS*COLORS-1:0] rgb
);
  localparam int N = CHANNELS * COLORS;
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  localparam logic [N-1:0] IDLE = OUT_ACTIVE_LOW != 0 ? '1 : '0;
  logic [PW-1:0] pre;
  logic [RES-1:0] cnt;
  logic [N*RES-1:0] staging, active;
  logic [N-1:0] on;
  logic tick, wrap, apply;
  assign tick = en && pre == PW'(PRESCALE - 1);
  assign wrap = tick && cnt == '1;
  // while disabled the bank is effectively at a period boundary, so staged data applies at once
  assign apply = wrap || !en;
  for (genvar k = 0; k < N; k++) begin : g_cmp
    logic [RES-1:0] ph;
`ifdef PWM_PHASE_STAGGER_EN
    assign ph = cnt + RES'((k / COLORS) * ((1 << RES) / CHANNELS));
`else
    assign ph = cnt;
`endif
    assign on[k] = ph < active[k*RES +: RES];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      pre <= '0;
      cnt <= '0;
      staging <= '0;
      active <= '0;
      load_pending <= 1'b0;
      period_start <= 1'b0;
      rgb <= IDLE;
    end else begin
      pre <= (!en || tick) ? '0 : pre + PW'(1);
      cnt <= !en ? '0 : cnt + RES'(tick);
      period_start <= wrap;
      if (load) staging <= duty_in;
      if (apply && load) active <= duty_in;
      else if (apply && load_pending) active <= staging;
      load_pending <= !apply && (load_pending || load);
      rgb <= en ? on ^ IDLE : IDLE;
    end
  end
endmodule
